// File: rtl/motor_spi_scheduler_pkg.sv
// motor_comm_pkg: shared types and constants for the motor board SPI link.
// Holds the scheduler state encoding, device index map and default word width.
package motor_comm_pkg;

    localparam int DEF_DATA_WIDTH = 16;

    localparam int DEV_DRV0 = 0;
    localparam int DEV_DRV1 = 1;
    localparam int DEV_DRV2 = 2;
    localparam int DEV_DRV3 = 3;
    localparam int DEV_DRV4 = 4;
    localparam int DEV_ADC0 = 5;
    localparam int DEV_ADC1 = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_XFER,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/motor_spi_scheduler_if.sv
// Link between the scheduler and the shared spi_master.
// master: drives m_go/m_datai, receives m_datao/m_done; slave: the reverse.
interface motor_spi_scheduler_if
    import motor_comm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  m_go;
    logic [DATA_WIDTH-1:0] m_datai;
    logic [DATA_WIDTH-1:0] m_datao;
    logic                  m_done;

    modport master (
        output m_go,
        output m_datai,
        input  m_datao,
        input  m_done
    );

    modport slave (
        input  m_go,
        input  m_datai,
        output m_datao,
        output m_done
    );
endinterface

// File: rtl/motor_spi_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from i_ptr+1.
// Ports: i_req (requests), i_ptr (last grant) -> o_idx (grant), o_valid.
module rr_arbiter #(
    parameter int NUM_DEV = 7,
    parameter int IDX_W   = $clog2(NUM_DEV)
) (
    input  logic [NUM_DEV-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);
    always_comb begin
        int j;
        j       = 0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= NUM_DEV; k++) begin
            j = (int'(i_ptr) + k) % NUM_DEV;
            if (!o_valid && i_req[IDX_W'(j)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/motor_spi_scheduler.sv
// motor_spi_scheduler: shares one spi_master among NUM_DEV chip selects.
// Ports: i_clk/i_reset, i_req/i_req_data in, o_ack/o_rsp_data/o_rsp_err/
// o_busy/o_dev_ncs out, m_if to the spi_master (go/datai out, datao/done in).
module motor_spi_scheduler
    import motor_comm_pkg::*;
#(
    parameter int NUM_DEV    = 7,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_IDLE    = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_DEV-1:0]            i_req,
    input  logic [NUM_DEV*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_DEV-1:0]            o_ack,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_rsp_err,
    output logic                          o_busy,
    output logic [NUM_DEV-1:0]            o_dev_ncs,
    motor_spi_scheduler_if.master         m_if
);
    localparam int IDX_W = $clog2(NUM_DEV);
    localparam int CNT_W =
        $clog2(max4(TIMEOUT, CS_SETUP, CS_HOLD, CS_IDLE) + 1);

    state_e                r_state, w_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic [IDX_W-1:0]      r_idx, w_idx, r_ptr, w_ptr, w_grant;
    logic                  w_valid, w_close;
    logic [DATA_WIDTH-1:0] r_tx, w_tx, w_sel_data;
    logic [DATA_WIDTH-1:0] r_rsp, w_rsp, r_rsp_out, w_rsp_out;
    logic                  r_err, w_err, r_err_out, w_err_out;
    logic [NUM_DEV-1:0]    r_ncs, w_ncs, r_ack, w_ack, w_sel_ncs;
    logic                  r_go, w_go, r_busy, w_busy;

    rr_arbiter #(
        .NUM_DEV (NUM_DEV),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_idx   (w_grant),
        .o_valid (w_valid)
    );

    always_comb begin
        w_sel_data = '0;
        w_sel_ncs  = '1;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_sel_data   = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_ncs[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt + CNT_W'(1);
        w_idx     = r_idx;
        w_ptr     = r_ptr;
        w_tx      = r_tx;
        w_rsp     = r_rsp;
        w_err     = r_err;
        w_rsp_out = r_rsp_out;
        w_err_out = r_err_out;
        w_ncs     = r_ncs;
        w_ack     = '0;
        w_go      = 1'b0;
        w_close   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt = '0;
                if (w_valid) begin
                    w_state = ST_SETUP;
                    w_idx   = w_grant;
                    w_ptr   = w_grant;
                    w_tx    = w_sel_data;
                    w_ncs   = w_sel_ncs;
                end
            end
            ST_SETUP: begin
                if (int'(r_cnt) == CS_SETUP - 1) begin
                    w_state = ST_START;
                    w_go    = 1'b1;
                end
            end
            ST_START: begin
                w_state = ST_XFER;
                w_cnt   = '0;
            end
            ST_XFER: begin
                // done beats a timeout landing in the same cycle
                if (m_if.m_done || int'(r_cnt) >= TIMEOUT) begin
                    w_rsp = m_if.m_done ? m_if.m_datao : '0;
                    w_err = !m_if.m_done;
                    if (CS_HOLD == 0) begin
                        w_close = 1'b1;
                    end else begin
                        w_state = ST_HOLD;
                        w_cnt   = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (int'(r_cnt) == CS_HOLD - 1) w_close = 1'b1;
            end
            ST_GAP: begin
                if (int'(r_cnt) == CS_IDLE - 1) begin
                    w_state = ST_IDLE;
                    w_cnt   = '0;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_ncs   = '1;
            end
        endcase
        // release ncs, pulse ack and publish the response together
        if (w_close) begin
            w_state   = ST_GAP;
            w_cnt     = '0;
            w_ncs     = '1;
            w_rsp_out = w_rsp;
            w_err_out = w_err;
            for (int i = 0; i < NUM_DEV; i++) begin
                w_ack[i] = (r_idx == IDX_W'(i));
            end
        end
        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_ptr     <= IDX_W'(NUM_DEV - 1);
            r_tx      <= '0;
            r_rsp     <= '0;
            r_err     <= 1'b0;
            r_rsp_out <= '0;
            r_err_out <= 1'b0;
            r_ncs     <= '1;
            r_ack     <= '0;
            r_go      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_ptr     <= w_ptr;
            r_tx      <= w_tx;
            r_rsp     <= w_rsp;
            r_err     <= w_err;
            r_rsp_out <= w_rsp_out;
            r_err_out <= w_err_out;
            r_ncs     <= w_ncs;
            r_ack     <= w_ack;
            r_go      <= w_go;
            r_busy    <= w_busy;
        end
    end

    assign o_ack        = r_ack;
    assign o_rsp_data   = r_rsp_out;
    assign o_rsp_err    = r_err_out;
    assign o_busy       = r_busy;
    assign o_dev_ncs    = r_ncs;
    assign m_if.m_go    = r_go;
    assign m_if.m_datai = r_tx;
endmodule
